// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Command front-end for the 8-bit ALU datapath. Accepts one operation per
//   cmd_valid/cmd_ready handshake, drives the ALU input-mux selector, both
//   operands and the one-hot output selector, captures the ALU result and
//   overflow flag, and returns them on a res_valid/res_ready port. Also owns
//   result chaining, the CLEAR operation and a saturating overflow counter.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_op              : 0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 CLEAR
//   cmd_chain           : use last captured result as operand A
//   cmd_a, cmd_b        : operands
//   alu_in_selector     : one-hot {persist, load, reset} to ALU input muxes
//   alu_num1, alu_num2  : operands to ALU
//   alu_out_selector    : one-hot output select, bit0=AND .. bit6=MULT
//   alu_result          : ALU output mux value
//   alu_overflow        : ALU multiply overflow
//   res_valid/res_ready : response handshake
//   res_data            : captured result
//   res_overflow        : overflow flag of this result (MULT only)
//   res_error           : chain requested with no valid prior result
//   ovf_count           : saturating count of overflowing responses
//   state               : current FSM state (debug/status)

module alu_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_chain,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [2:0]       alu_in_selector,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [6:0]       alu_out_selector,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_overflow,
  output logic             res_error,
  output logic [CNT_W-1:0] ovf_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    EXEC  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic [2:0] OP_MULT   = 3'd6;
  localparam logic [2:0] OP_CLEAR  = 3'd7;
  localparam logic [2:0] SEL_RESET = 3'b001;
  localparam logic [2:0] SEL_LOAD  = 3'b010;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   last_result_q;
  logic               chain_valid_q;
  logic [WIDTH-1:0]   res_data_q;
  logic               res_ovf_q;
  logic               res_err_q;
  logic [CNT_W-1:0]   ovf_cnt_q;
  logic [CNT_W-1:0]   ovf_cnt_d;
  logic [2:0]         in_sel_q;
  logic [WIDTH-1:0]   num1_q;
  logic [WIDTH-1:0]   num2_q;
  logic [6:0]         out_sel_q;
  logic [6:0]         out_sel_d;
  logic               cmd_err;
  logic               res_hs;

  always_comb begin
    cmd_err   = cmd_chain && !chain_valid_q;
    res_hs    = (state_q == RESP) && res_ready;
    out_sel_d = '0;
    if (cmd_op != OP_CLEAR) out_sel_d = 7'b000_0001 << cmd_op;
    ovf_cnt_d = ovf_cnt_q;
    if (res_hs && res_ovf_q && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= '0;
      last_result_q <= '0;
      chain_valid_q <= 1'b0;
      res_data_q    <= '0;
      res_ovf_q     <= 1'b0;
      res_err_q     <= 1'b0;
      ovf_cnt_q     <= '0;
      in_sel_q      <= '0;
      num1_q        <= '0;
      num2_q        <= '0;
      out_sel_q     <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            if (cmd_err) begin
              // Rejected chain: respond immediately, ALU stays idle.
              state_q    <= RESP;
              res_err_q  <= 1'b1;
              res_data_q <= '0;
              res_ovf_q  <= 1'b0;
            end else begin
              // ALU drive is registered here so it is present throughout ISSUE.
              state_q   <= ISSUE;
              res_err_q <= 1'b0;
              in_sel_q  <= (cmd_op == OP_CLEAR) ? SEL_RESET : SEL_LOAD;
              num1_q    <= cmd_chain ? last_result_q : cmd_a;
              num2_q    <= cmd_b;
              out_sel_q <= out_sel_d;
            end
          end
        end
        ISSUE: begin
          // Operands now sit in the ALU registers; keep the output select.
          in_sel_q <= '0;
          state_q  <= EXEC;
        end
        EXEC: begin
          if (op_q == OP_CLEAR) begin
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
          end else begin
            res_data_q <= alu_result;
            res_ovf_q  <= alu_overflow && (op_q == OP_MULT);
          end
          in_sel_q  <= '0;
          num1_q    <= '0;
          num2_q    <= '0;
          out_sel_q <= '0;
          state_q   <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            state_q <= IDLE;
            if (!res_err_q) begin
              if (op_q == OP_CLEAR) begin
                last_result_q <= '0;
                chain_valid_q <= 1'b0;
              end else begin
                last_result_q <= res_data_q;
                chain_valid_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready        = (state_q == IDLE);
  assign res_valid        = (state_q == RESP);
  assign res_data         = res_data_q;
  assign res_overflow     = res_ovf_q;
  assign res_error        = res_err_q;
  assign ovf_count        = ovf_cnt_q;
  assign alu_in_selector  = in_sel_q;
  assign alu_num1         = num1_q;
  assign alu_num2         = num2_q;
  assign alu_out_selector = out_sel_q;
  assign state            = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a small ALU environment model answers the
// sequencer's drive, and a transaction-level reference model predicts each
// response, chaining state and the overflow counter.

module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_chain;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] alu_in_selector;
  logic [7:0] alu_num1, alu_num2;
  logic [6:0] alu_out_selector;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_overflow;
  logic       res_error;
  logic [7:0] ovf_count;
  logic [1:0] state;

  int compared = 0;
  int mismatched = 0;

  alu_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_chain(cmd_chain), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_in_selector(alu_in_selector), .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_selector(alu_out_selector), .alu_result(alu_result),
    .alu_overflow(alu_overflow), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_overflow(res_overflow), .res_error(res_error),
    .ovf_count(ovf_count), .state(state)
  );

  always #5 clk = ~clk;

  // ALU environment: operand registers loaded/reset by the input selector,
  // output picked by the one-hot output selector.
  logic [7:0] r1 = '0, r2 = '0;
  always @(posedge clk) begin
    if (alu_in_selector == 3'b001) begin
      r1 <= '0; r2 <= '0;
    end else if (alu_in_selector == 3'b010) begin
      r1 <= alu_num1; r2 <= alu_num2;
    end
  end
  always @* begin
    case (alu_out_selector)
      7'h01:   alu_result = r1 & r2;
      7'h02:   alu_result = r1 | r2;
      7'h04:   alu_result = ~r1;
      7'h08:   alu_result = r1 ^ r2;
      7'h10:   alu_result = r1 + r2;
      7'h20:   alu_result = r1 - r2;
      7'h40:   alu_result = 8'(16'(r1) * 16'(r2));
      default: alu_result = 8'h00;
    endcase
    alu_overflow = (16'(r1) * 16'(r2)) > 16'd255;
  end

  typedef struct {
    logic [2:0] in_sel;
    logic [6:0] out_sel;
    logic [7:0] num1, num2;
    logic       rdy_during;
    int         lat;
    logic [7:0] data;
    logic       ovf, err;
    logic       stable;
    logic       rdy_after;
    logic [1:0] st_after;
    logic [7:0] cnt;
  } obs_t;

  // Reference model state
  logic [7:0] m_last = '0;
  logic       m_cv   = 1'b0;
  logic [7:0] m_cnt  = '0;

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return a ^ b;
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return p[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_last = '0; m_cv = 1'b0; m_cnt = '0;
  endtask

  task automatic model_cmd(input logic [2:0] op, input logic ch, input logic [7:0] a, b,
                           output obs_t e);
    logic [7:0] opa;
    logic [6:0] oh_tab [8];
    oh_tab = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h00};
    e.err = ch && !m_cv;
    e.lat = e.err ? 1 : 3;
    e.rdy_during = 1'b0; e.rdy_after = 1'b1; e.st_after = 2'b00; e.stable = 1'b1;
    if (e.err) begin
      e.in_sel = 3'b000; e.out_sel = '0; e.num1 = '0; e.num2 = '0;
      e.data = '0; e.ovf = 1'b0;
    end else begin
      opa = ch ? m_last : a;
      e.in_sel  = (op == 3'd7) ? 3'b001 : 3'b010;
      e.out_sel = oh_tab[op];
      e.num1 = opa; e.num2 = b;
      e.data = ref_alu(op, opa, b);
      e.ovf  = (op == 3'd6) && ((16'(opa) * 16'(b)) > 16'd255);
      if (op == 3'd7) begin m_last = '0; m_cv = 1'b0; end
      else begin m_last = e.data; m_cv = 1'b1; end
    end
    if (e.ovf && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    e.cnt = m_cnt;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drives one command and collects what the DUT shows; no judgement here.
  task automatic run_cmd(input logic [2:0] op, input logic ch, input logic [7:0] a, b,
                         input int hold, output obs_t o);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin step(); w++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_chain = ch; cmd_a = a; cmd_b = b;
    step();
    cmd_valid = 1'b0;
    o.in_sel = alu_in_selector; o.out_sel = alu_out_selector;
    o.num1 = alu_num1; o.num2 = alu_num2; o.rdy_during = cmd_ready;
    o.lat = 1;
    while (res_valid !== 1'b1 && o.lat < 10) begin step(); o.lat++; end
    if (res_valid !== 1'b1) o.lat = -1;
    o.data = res_data; o.ovf = res_overflow; o.err = res_error;
    o.stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = (i == 0); cmd_op = 3'($urandom); cmd_chain = 1'b0;
      cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      step();
      cmd_valid = 1'b0;
      if (res_valid !== 1'b1 || res_data !== o.data || res_overflow !== o.ovf ||
          res_error !== o.err || cmd_ready !== 1'b0) o.stable = 1'b0;
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    o.rdy_after = cmd_ready; o.st_after = state; o.cnt = ovf_count;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    model_reset();
    compared++;
    if ({state, cmd_ready, res_valid} !== 4'b0010) begin
      mismatched++;
      $display("FAIL reset_ctrl: state/rdy/valid got %b expected %b", {state, cmd_ready, res_valid}, 4'b0010);
    end
    compared++;
    if ({res_data, res_overflow, res_error, ovf_count} !== 18'h0) begin
      mismatched++;
      $display("FAIL reset_resp: got %h expected 0", {res_data, res_overflow, res_error, ovf_count});
    end
    compared++;
    if ({alu_in_selector, alu_out_selector, alu_num1, alu_num2} !== 26'h0) begin
      mismatched++;
      $display("FAIL reset_alu: got %h expected 0", {alu_in_selector, alu_out_selector, alu_num1, alu_num2});
    end
  endtask

  task automatic test_chain_error();
    obs_t o, e;
    model_cmd(3'd4, 1'b1, 8'h05, 8'h06, e);
    run_cmd(3'd4, 1'b1, 8'h05, 8'h06, 0, o);
    compared++;
    if (o.lat !== 1 || o.err !== 1'b1 || o.data !== 8'h00) begin
      mismatched++;
      $display("FAIL chain_err: lat=%0d err=%b data=%h expected lat=1 err=1 data=00", o.lat, o.err, o.data);
    end
    compared++;
    if ({o.in_sel, o.out_sel, o.num1} !== 18'h0) begin
      mismatched++;
      $display("FAIL chain_err_alu: got %h expected 0", {o.in_sel, o.out_sel, o.num1});
    end
  endtask

  task automatic test_add();
    obs_t o, e;
    model_cmd(3'd4, 1'b0, 8'h12, 8'h34, e);
    run_cmd(3'd4, 1'b0, 8'h12, 8'h34, 0, o);
    compared++;
    if (o.in_sel !== 3'b010 || o.out_sel !== 7'b0010000) begin
      mismatched++;
      $display("FAIL add_issue: in_sel=%b out_sel=%b expected 010 0010000", o.in_sel, o.out_sel);
    end
    compared++;
    if (o.lat !== 3 || o.data !== 8'h46 || o.ovf !== 1'b0) begin
      mismatched++;
      $display("FAIL add_resp: lat=%0d data=%h ovf=%b expected 3 46 0", o.lat, o.data, o.ovf);
    end
    compared++;
    if (o.rdy_during !== 1'b0 || o.rdy_after !== 1'b1) begin
      mismatched++;
      $display("FAIL add_ready: during=%b after=%b expected 0 1", o.rdy_during, o.rdy_after);
    end
  endtask

  task automatic test_chain();
    obs_t o, e;
    model_cmd(3'd4, 1'b0, 8'h01, 8'h02, e);
    run_cmd(3'd4, 1'b0, 8'h01, 8'h02, 0, o);
    model_cmd(3'd5, 1'b1, 8'hAA, 8'h01, e);
    run_cmd(3'd5, 1'b1, 8'hAA, 8'h01, 0, o);
    compared++;
    if (o.num1 !== 8'h03 || o.num2 !== 8'h01) begin
      mismatched++;
      $display("FAIL chain_num: num1=%h num2=%h expected 03 01", o.num1, o.num2);
    end
    compared++;
    if (o.data !== 8'h02 || o.err !== 1'b0) begin
      mismatched++;
      $display("FAIL chain_data: data=%h err=%b expected 02 0", o.data, o.err);
    end
  endtask

  task automatic test_clear();
    obs_t o, e;
    model_cmd(3'd7, 1'b0, 8'h55, 8'h66, e);
    run_cmd(3'd7, 1'b0, 8'h55, 8'h66, 0, o);
    compared++;
    if (o.in_sel !== 3'b001 || o.out_sel !== 7'b0 || o.data !== 8'h00 || o.lat !== 3) begin
      mismatched++;
      $display("FAIL clear: in_sel=%b out_sel=%b data=%h lat=%0d expected 001 0 00 3",
               o.in_sel, o.out_sel, o.data, o.lat);
    end
    model_cmd(3'd0, 1'b1, 8'hFF, 8'hFF, e);
    run_cmd(3'd0, 1'b1, 8'hFF, 8'hFF, 0, o);
    compared++;
    if (o.err !== 1'b1 || o.lat !== 1) begin
      mismatched++;
      $display("FAIL clear_chain: err=%b lat=%0d expected 1 1", o.err, o.lat);
    end
  endtask

  task automatic test_mult_sat();
    obs_t o, e;
    int bad;
    model_cmd(3'd6, 1'b0, 8'h20, 8'h10, e);
    run_cmd(3'd6, 1'b0, 8'h20, 8'h10, 0, o);
    compared++;
    if (o.ovf !== 1'b1 || o.cnt !== e.cnt || o.data !== 8'h00) begin
      mismatched++;
      $display("FAIL mult_ovf: ovf=%b cnt=%h data=%h expected 1 %h 00", o.ovf, o.cnt, o.data, e.cnt);
    end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      model_cmd(3'd6, 1'b0, 8'h20, 8'h10, e);
      run_cmd(3'd6, 1'b0, 8'h20, 8'h10, 0, o);
      if (o.cnt !== e.cnt) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL ovf_track: %0d counter steps wrong, required 0", bad);
    end
    compared++;
    if (ovf_count !== 8'hFF) begin
      mismatched++;
      $display("FAIL ovf_sat: got %h expected ff", ovf_count);
    end
  endtask

  task automatic test_backpressure();
    obs_t o, e;
    model_cmd(3'd3, 1'b0, 8'h5A, 8'h0F, e);
    run_cmd(3'd3, 1'b0, 8'h5A, 8'h0F, 5, o);
    compared++;
    if (o.stable !== 1'b1 || o.data !== 8'h55) begin
      mismatched++;
      $display("FAIL backpressure: stable=%b data=%h expected 1 55", o.stable, o.data);
    end
    // The pulsed command during backpressure must leave no trace.
    for (int i = 0; i < 4; i++) step();
    compared++;
    if (state !== 2'b00 || res_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_ignored: state=%b res_valid=%b expected 00 0", state, res_valid);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    model_cmd(3'd1, 1'b0, 8'h0F, 8'hF0, e);
    run_cmd(3'd1, 1'b0, 8'h0F, 8'hF0, 0, o);
    // Start a second command with the response still pending, then
    // handshake and present a new command on the same cycle.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_chain = 1'b0; cmd_a = 8'hF3; cmd_b = 8'h3F;
    step(); cmd_valid = 1'b0;
    model_cmd(3'd0, 1'b0, 8'hF3, 8'h3F, e);
    step(); step();
    cmd_valid = 1'b1; res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    compared++;
    if (state !== 2'b00 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL hs_and_cmd: state=%b rdy=%b valid=%b expected 00 1 0", state, cmd_ready, res_valid);
    end
    cmd_valid = 1'b0;
    step();
    compared++;
    if (state !== 2'b00) begin
      mismatched++;
      $display("FAIL hs_cmd_dropped: state=%b expected 00", state);
    end
  endtask

  task automatic test_reset_exec();
    obs_t o, e;
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin step(); w++; end
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_chain = 1'b0; cmd_a = 8'h01; cmd_b = 8'h01;
    step(); cmd_valid = 1'b0;
    step();
    compared++;
    if (state !== 2'b10) begin
      mismatched++;
      $display("FAIL exec_state: got %b expected 10", state);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    compared++;
    if ({state, res_valid, cmd_ready, ovf_count} !== {2'b00, 1'b0, 1'b1, 8'h00}) begin
      mismatched++;
      $display("FAIL rst_exec: got %h expected %h", {state, res_valid, cmd_ready, ovf_count},
               {2'b00, 1'b0, 1'b1, 8'h00});
    end
    model_cmd(3'd4, 1'b1, 8'h00, 8'h00, e);
    run_cmd(3'd4, 1'b1, 8'h00, 8'h00, 0, o);
    compared++;
    if (o.err !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_chain_valid: err=%b expected 1", o.err);
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [2:0] op;
    logic ch;
    logic [7:0] a, b;
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom); ch = ($urandom_range(0, 2) == 0);
      a = 8'($urandom); b = 8'($urandom);
      model_cmd(op, ch, a, b, e);
      run_cmd(op, ch, a, b, $urandom_range(0, 2), o);
      compared++;
      if ({o.in_sel, o.out_sel, o.num1, o.num2, o.data, o.ovf, o.err, o.cnt, o.stable, o.rdy_after} !==
          {e.in_sel, e.out_sel, e.num1, e.num2, e.data, e.ovf, e.err, e.cnt, e.stable, e.rdy_after} ||
          o.lat != e.lat) begin
        mismatched++;
        $display("FAIL rand[%0d] op=%0d ch=%b: got sel=%b/%b n=%h/%h d=%h o=%b e=%b c=%h lat=%0d, expected sel=%b/%b n=%h/%h d=%h o=%b e=%b c=%h lat=%0d",
                 i, op, ch, o.in_sel, o.out_sel, o.num1, o.num2, o.data, o.ovf, o.err, o.cnt, o.lat,
                 e.in_sel, e.out_sel, e.num1, e.num2, e.data, e.ovf, e.err, e.cnt, e.lat);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_chain = 1'b0;
    cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    test_reset();
    test_chain_error();
    test_add();
    test_chain();
    test_clear();
    test_mult_sat();
    test_backpressure();
    test_back_to_back();
    test_reset_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command front-end that sits directly upstream of the 8-bit ALU datapath. It accepts one operation per valid/ready handshake and drives the ALU's input-mux selector, both operands and the one-hot output selector. It then captures the ALU result and overflow flag one cycle after the operand registers load, and returns the result through a valid/ready response port. It also owns result chaining (previous result as operand A), the clear operation, and a saturating overflow counter.

## Interface
Parameters:
- WIDTH, 8, operand/result width (matches ALU datapath)
- CNT_W, 8, overflow counter width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_op  in  3  0=AND 1=OR 2=NOT 3=XOR 4=ADD 5=SUB 6=MULT 7=CLEAR
- cmd_chain  in  1  1: operand A = last captured result instead of cmd_a
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- alu_in_selector  out  3  one-hot {persist, load, reset} to ALU input muxes
- alu_num1  out  WIDTH  operand A to ALU
- alu_num2  out  WIDTH  operand B to ALU
- alu_out_selector  out  7  one-hot {mult, sub, add, xor, not, or, and}; bit0=AND … bit6=MULT
- alu_result  in  WIDTH  ALU output mux value
- alu_overflow  in  1  ALU multiply overflow
- res_valid  out  1  response present
- res_ready  in  1  consumer accepts response
- res_data  out  WIDTH  captured result
- res_overflow  out  1  overflow flag for this result
- res_error  out  1  command rejected (chain with no valid prior result)
- ovf_count  out  CNT_W  saturating count of responses with res_overflow=1
- state  out  2  current FSM state, for debug/status

## Operation
- States: IDLE=2'b00, ISSUE=2'b01, EXEC=2'b10, RESP=2'b11.
- IDLE: cmd_ready=1. On cmd_valid, latch op, chain, a and b.
  - Legal command: go to ISSUE.
  - cmd_chain=1 while chain_valid=0: go directly to RESP with res_error=1, res_data=0 and res_overflow=0. No ALU cycle is issued.
- ISSUE (1 cycle):
  - alu_in_selector=3'b010 (load), or 3'b001 (reset) for CLEAR.
  - alu_num1 = last_result if chain, else latched a. alu_num2 = latched b.
  - alu_out_selector = one-hot of op (CLEAR: 7'b0).
- EXEC (1 cycle):
  - alu_out_selector is held. alu_in_selector=3'b000.
  - At the end of the cycle, capture res_data=alu_result and res_overflow=alu_overflow & (op==MULT). Then go to RESP.
  - CLEAR captures res_data=0 and res_overflow=0.
- RESP: res_valid=1 and outputs are held stable until res_ready=1, then go to IDLE.
- On the handshake of a non-error response:
  - last_result <= res_data and chain_valid <= 1.
  - If op is CLEAR: last_result <= 0 and chain_valid <= 0.
- ovf_count increments on each response handshake with res_overflow=1. It saturates at all-ones and never wraps.
- Outside ISSUE/EXEC: alu_in_selector=0, alu_out_selector=0, alu_num1/alu_num2=0.
- NOT ignores operand B. Arithmetic is performed entirely by the ALU; the sequencer does no width extension.

## Timing
- Reset values: state=IDLE, cmd_ready=1, res_valid=0, res_data=0, res_overflow=0, res_error=0, ovf_count=0, all alu_* outputs 0, last_result=0, chain_valid=0.
- Command accepted at edge T: ISSUE during cycle T+1, EXEC during T+2, res_valid=1 from T+3.
- Minimum command-to-command spacing is 4 cycles: cmd_ready returns the cycle after the response handshake.
- Error path: res_valid=1 at T+1.
- cmd_valid while not IDLE is ignored; cmd_ready=0.
- res_valid must not drop without a handshake. Data is unchanged while res_ready=0.
- rst in any state returns to IDLE on the next edge, dropping any in-flight command and response. It also clears chain_valid and ovf_count.
- A response handshake and a new cmd_valid in the same cycle: the command is not accepted until the following IDLE cycle.

## Test plan
- Reset, then ADD a=8'h12 b=8'h34: alu_in_selector=010 and alu_out_selector=7'b0010000 at T+1; res_data=8'h46 at T+3; res_overflow=0.
- MULT a=8'h20 b=8'h10 with ALU overflow=1: res_overflow=1 and ovf_count=1 after the handshake. Repeat 300 times: ovf_count saturates at 8'hFF.
- Chain directly after reset: res_error=1 at T+1, no ALU activity. After ADD 1+2=3, chain SUB b=1: alu_num1=8'h03, res_data=8'h02.
- CLEAR: alu_in_selector=001 at ISSUE, res_data=0. A following chain command returns res_error=1.
- Backpressure: hold res_ready=0 for 5 cycles. res_valid and res_data stay stable, cmd_ready=0, and a pulsed cmd_valid is ignored.
- Assert rst during EXEC: next cycle state=IDLE, res_valid=0, cmd_ready=1, ovf_count=0.
